// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//
// Sequencer/arbiter that lets two requesters (A and B) share one 16-bit
// load/shift register (reg_8). A round-robin arbiter picks a winner from IDLE.
// The winner's word is presented on D with Load for one cycle. The block then
// asserts Shift_En for N_SHIFTS cycles and collects the register's serial
// output into Result, LSB first (each new bit enters at the MSB).
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally, so the block can sit next to reg_8 without creating
// a loop through Shift_Out.
//
// Parameters
//   WIDTH     data width; must match reg_8
//   N_SHIFTS  shifts per transaction, 1..WIDTH
//
// Ports
//   Clk        in   clock, all state updates on posedge
//   Reset      in   synchronous active-high reset
//   Req_A/B    in   level requests from the two clients
//   Data_A/B   in   client words, sampled at grant
//   Fill_Bit   in   serial fill value, sampled at grant
//   Abort      in   cancel the active transaction (LOAD/SHIFT only)
//   Shift_Out  in   reg_8 bit 0
//   Load       out  reg_8 parallel load strobe
//   Shift_En   out  reg_8 shift enable
//   Shift_In   out  reg_8 serial input (latched fill bit)
//   D          out  reg_8 parallel data (the held word)
//   Ack_A/B    out  one-cycle grant pulse, coincides with Load
//   Busy       out  high outside IDLE
//   Done       out  one-cycle completion pulse
//   Done_Id    out  owner of the latest grant: 0=A, 1=B
//   Result     out  bits collected from Shift_Out
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
  parameter int WIDTH    = 16,
  parameter int N_SHIFTS = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req_A,
  input  logic             Req_B,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  input  logic             Fill_Bit,
  input  logic             Abort,
  input  logic             Shift_Out,
  output logic             Load,
  output logic             Shift_En,
  output logic             Shift_In,
  output logic [WIDTH-1:0] D,
  output logic             Ack_A,
  output logic             Ack_B,
  output logic             Busy,
  output logic             Done,
  output logic             Done_Id,
  output logic [WIDTH-1:0] Result
);

  // Counter wide enough to hold N_SHIFTS-1 for any legal N_SHIFTS <= WIDTH.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SHIFTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic             ptr_q,    ptr_d;     // 0: A wins a tie, 1: B wins a tie
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] hold_q,   hold_d;
  logic             fill_q,   fill_d;
  logic             owner_q,  owner_d;   // 0=A, 1=B
  logic [WIDTH-1:0] result_q, result_d;

  // B wins when it is the only requester, or on a tie with the pointer at B.
  logic win_b;
  logic any_req;

  assign any_req = Req_A | Req_B;
  assign win_b   = Req_B & (~Req_A | ptr_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    fill_d   = fill_q;
    owner_d  = owner_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = LOAD;
          owner_d  = win_b;
          hold_d   = win_b ? Data_B : Data_A;
          fill_d   = Fill_Bit;
          result_d = '0;
          // Next tie goes to whichever side did not just win.
          ptr_d    = ~win_b;
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = Abort ? IDLE : SHIFT;
      end

      SHIFT: begin
        // reg_8 shifts on this edge whether or not Abort is high, so the
        // bit it presents now is captured either way; Result then holds
        // exactly the bits that actually left the register.
        result_d = {Shift_Out, result_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (Abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      hold_q   <= '0;
      fill_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      fill_q   <= fill_d;
      owner_q  <= owner_d;
      result_q <= result_d;
    end
  end

  // Moore output decode
  assign Load     = (state_q == LOAD);
  assign Shift_En = (state_q == SHIFT);
  assign Shift_In = (state_q == SHIFT) & fill_q;
  assign Ack_A    = (state_q == LOAD) & ~owner_q;
  assign Ack_B    = (state_q == LOAD) &  owner_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign Done_Id  = owner_q;
  assign D        = hold_q;
  assign Result   = result_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (N_SHIFTS = 16)
  logic        req_a = 0, req_b = 0, fill = 0, abort = 0, shift_out;
  logic [15:0] data_a = 0, data_b = 0;
  logic        load, shift_en, shift_in, ack_a, ack_b, busy, done, done_id;
  logic [15:0] d, result;

  // Short instance (N_SHIFTS = 4)
  logic        s_req_a = 0, s_req_b = 0, s_fill = 0, s_abort = 0, s_shift_out;
  logic [15:0] s_data_a = 0, s_data_b = 0;
  logic        s_load, s_shift_en, s_shift_in, s_ack_a, s_ack_b, s_busy, s_done, s_done_id;
  logic [15:0] s_d, s_result;

  shift_reg_ctrl #(.WIDTH(16), .N_SHIFTS(16)) dut (
    .Clk(clk), .Reset(rst), .Req_A(req_a), .Req_B(req_b),
    .Data_A(data_a), .Data_B(data_b), .Fill_Bit(fill), .Abort(abort),
    .Shift_Out(shift_out), .Load(load), .Shift_En(shift_en), .Shift_In(shift_in),
    .D(d), .Ack_A(ack_a), .Ack_B(ack_b), .Busy(busy), .Done(done),
    .Done_Id(done_id), .Result(result)
  );

  shift_reg_ctrl #(.WIDTH(16), .N_SHIFTS(4)) dut_s (
    .Clk(clk), .Reset(rst), .Req_A(s_req_a), .Req_B(s_req_b),
    .Data_A(s_data_a), .Data_B(s_data_b), .Fill_Bit(s_fill), .Abort(s_abort),
    .Shift_Out(s_shift_out), .Load(s_load), .Shift_En(s_shift_en), .Shift_In(s_shift_in),
    .D(s_d), .Ack_A(s_ack_a), .Ack_B(s_ack_b), .Busy(s_busy), .Done(s_done),
    .Done_Id(s_done_id), .Result(s_result)
  );

  // Behavioural reg_8 for each instance: parallel load, right shift, bit 0 out.
  logic [15:0] r8, s_r8;
  always_ff @(posedge clk) begin
    if (rst)           r8 <= '0;
    else if (load)     r8 <= d;
    else if (shift_en) r8 <= {shift_in, r8[15:1]};
  end
  always_ff @(posedge clk) begin
    if (rst)             s_r8 <= '0;
    else if (s_load)     s_r8 <= s_d;
    else if (s_shift_en) s_r8 <= {s_shift_in, s_r8[15:1]};
  end
  assign shift_out   = r8[0];
  assign s_shift_out = s_r8[0];

  int n_tests = 0;
  int n_fail  = 0;
  bit m_ptr   = 0;   // reference arbiter: 0 -> A wins a tie

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance, checked against the reference.
  // abort_at: 0 = none, k = Abort asserted during the k-th shift cycle.
  task automatic txn(input bit ra, input bit rb, input logic [15:0] da,
                     input logic [15:0] db, input bit fl, input int abort_at,
                     input bit keep_req, input string tag);
    bit          win;
    logic [15:0] word, exp;
    logic [31:0] w32;
    win  = (ra && rb) ? m_ptr : rb;
    word = win ? db : da;
    req_a = ra; req_b = rb; data_a = da; data_b = db; fill = fl; abort = 0;
    tick();
    m_ptr = !win;
    n_tests++;
    if ({load, ack_a, ack_b, shift_en, done, busy} !== {1'b1, !win, win, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s grant_ctl: got %b want %b", tag,
               {load, ack_a, ack_b, shift_en, done, busy}, {1'b1, !win, win, 1'b0, 1'b0, 1'b1});
    end
    n_tests++;
    if (d !== word || done_id !== win) begin
      n_fail++;
      $display("FAIL %s grant_data: got D=%h id=%b want D=%h id=%b", tag, d, done_id, word, win);
    end
    if (!keep_req) begin req_a = 0; req_b = 0; end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_tests++;
      if ({shift_en, shift_in, load, ack_a, ack_b, done} !== {1'b1, fl, 4'b0000}) begin
        n_fail++;
        $display("FAIL %s shift%0d: got %b want %b", tag, k,
                 {shift_en, shift_in, load, ack_a, ack_b, done}, {1'b1, fl, 4'b0000});
      end
      if (k == abort_at) begin
        abort = 1;
        tick();
        abort = 0;
        w32 = {16'h0, word};
        w32 = (w32 & ((32'h1 << k) - 1)) << (16 - k);
        exp = w32[15:0];
        n_tests++;
        if ({busy, shift_en, done} !== 3'b000 || result !== exp) begin
          n_fail++;
          $display("FAIL %s abort@%0d: got ctl=%b res=%h want ctl=000 res=%h", tag, k,
                   {busy, shift_en, done}, result, exp);
        end
        return;
      end
    end
    tick();
    n_tests++;
    if ({done, busy, shift_en} !== 3'b110 || done_id !== win || result !== word) begin
      n_fail++;
      $display("FAIL %s done: got ctl=%b id=%b res=%h want ctl=110 id=%b res=%h", tag,
               {done, busy, shift_en}, done_id, result, win, word);
    end
    tick();
    n_tests++;
    if ({busy, done, load} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle_after: got %b want 000", tag, {busy, done, load});
    end
  endtask

  task automatic test_reset();
    rst = 1; req_a = 1; req_b = 1; data_a = 16'h1234; data_b = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({busy, load, shift_en, ack_a, ack_b, done, done_id, shift_in} !== 8'h00 ||
          result !== 16'h0 || d !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got ctl=%b res=%h d=%h want all zero", i,
                 {busy, load, shift_en, ack_a, ack_b, done, done_id, shift_in}, result, d);
      end
    end
    rst = 0;
    tick();
    n_tests++;
    if ({ack_a, ack_b, load} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_ptr: got ack_a/ack_b/load=%b want 101", {ack_a, ack_b, load});
    end
    req_a = 0; req_b = 0;
    rst = 1; tick(); rst = 0;
    m_ptr = 0;
  endtask

  task automatic test_single_a();
    txn(1, 0, 16'hA5C3, 16'h0000, 0, 0, 0, "single_a");
    txn(0, 1, 16'h0000, 16'h3C5A, 1, 0, 0, "single_b_fill");
  endtask

  task automatic test_arbitration();
    txn(1, 1, 16'h1111, 16'h2222, 0, 0, 1, "arb1");
    txn(1, 1, 16'h3333, 16'h4444, 0, 0, 1, "arb2");
    txn(1, 1, 16'h5555, 16'h6666, 1, 0, 0, "arb3");
  endtask

  task automatic test_abort();
    txn(0, 1, 16'h0000, 16'h00FF, 0, 5, 0, "abort5");
    // Abort during LOAD: no shifting, Result was cleared at grant.
    req_a = 1; data_a = 16'hBEEF;
    tick();
    m_ptr = 1;
    req_a = 0; abort = 1;
    tick();
    abort = 0;
    n_tests++;
    if ({busy, shift_en, done} !== 3'b000 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_load: got ctl=%b res=%h want ctl=000 res=0000",
               {busy, shift_en, done}, result);
    end
    // Abort in IDLE is ignored; a request in the same cycle is still granted.
    abort = 1; req_a = 1; req_b = 1; data_a = 16'h0F0F; data_b = 16'hF0F0;
    tick();
    abort = 0; req_a = 0; req_b = 0;
    n_tests++;
    if ({load, ack_b, d} !== {2'b11, 16'hF0F0}) begin
      n_fail++;
      $display("FAIL abort_idle: got load/ack_b/d=%b/%b/%h want 1/1/f0f0", load, ack_b, d);
    end
    m_ptr = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset_mid();
    req_b = 1; data_b = 16'hC0DE;
    tick();
    req_b = 0;
    for (int i = 2; i <= 8; i++) tick();
    rst = 1;
    tick();
    m_ptr = 0;
    n_tests++;
    if ({busy, shift_en, load, done} !== 4'b0000 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got ctl=%b res=%h want ctl=0000 res=0000",
               {busy, shift_en, load, done}, result);
    end
    rst = 0;
    txn(1, 1, 16'h9A7E, 16'h0BAD, 0, 0, 0, "after_reset");
  endtask

  task automatic test_short();
    logic [15:0] sd, exp_res, exp_reg;
    bit          sf;
    for (int t = 0; t < 4; t++) begin
      sd = (t == 0) ? 16'h000F : 16'($urandom);
      sf = (t == 0) ? 1'b1 : 1'($urandom);
      s_req_a = 1; s_data_a = sd; s_fill = sf;
      tick();
      s_req_a = 0;
      n_tests++;
      if ({s_load, s_ack_a, s_d} !== {2'b11, sd}) begin
        n_fail++;
        $display("FAIL short%0d_load: got %b%b %h want 11 %h", t, s_load, s_ack_a, s_d, sd);
      end
      for (int k = 1; k <= 4; k++) begin
        tick();
        n_tests++;
        if ({s_shift_en, s_shift_in, s_done} !== {1'b1, sf, 1'b0}) begin
          n_fail++;
          $display("FAIL short%0d_shift%0d: got %b want %b", t, k,
                   {s_shift_en, s_shift_in, s_done}, {1'b1, sf, 1'b0});
        end
      end
      tick();
      exp_res = {sd[3:0], 12'h000};
      exp_reg = {{4{sf}}, sd[15:4]};
      n_tests++;
      if (s_done !== 1'b1 || s_done_id !== 1'b0 || s_result !== exp_res || s_r8 !== exp_reg) begin
        n_fail++;
        $display("FAIL short%0d_done: got done=%b id=%b res=%h reg=%h want 1 0 %h %h", t,
                 s_done, s_done_id, s_result, s_r8, exp_res, exp_reg);
      end
      tick();
      n_tests++;
      if (s_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL short%0d_idle: got busy=%b want 0", t, s_busy);
      end
    end
  endtask

  task automatic test_random();
    bit ra, rb;
    int ab, gap;
    for (int t = 0; t < 24; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        abort = 1'($urandom);
        tick();
        abort = 0;
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd%0d_gap: got busy=%b want 0", t, busy);
        end
      end
      do begin
        ra = 1'($urandom); rb = 1'($urandom);
      end while (!ra && !rb);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      txn(ra, rb, 16'($urandom), 16'($urandom), 1'($urandom), ab, 0, $sformatf("rnd%0d", t));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_single_a();
    test_arbitration();
    test_abort();
    test_reset_mid();
    test_short();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
